// File: rtl/rx_frame_packer.sv
// Receive byte packer: buffers the 8-bit receive stream in a small FIFO and packs
// it little-endian into a 32-bit AXI-Stream with tkeep/tlast, frame length and overflow.
module rx_frame_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic                 s_tlast,
  input  logic [7:0]           s_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic [31:0]          m_tdata,
  output logic [3:0]           m_tkeep,
  output logic [LEN_WIDTH-1:0] frame_len,
  output logic                 frame_done,
  output logic                 overflow,
  input  logic                 clr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [8:0]           r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wr_ptr, r_rd_ptr;
  logic                 r_head_valid;
  logic [8:0]           r_head;
  logic [1:0]           r_lane;
  logic [23:0]          r_lanes;
  logic [LEN_WIDTH-1:0] r_byte_cnt, r_pending, r_frame_len;
  logic                 r_frame_done, r_overflow;
  logic                 r_m_tvalid, r_m_tlast;
  logic [31:0]          r_m_tdata;
  logic [3:0]           r_m_tkeep;

  logic                 w_full, w_empty, w_wr;
  logic                 w_completing, w_out_free, w_pop, w_head_load, w_m_hs;
  logic [7:0]           w_byte;
  logic [31:0]          w_word;
  logic [3:0]           w_keep;
  logic [LEN_WIDTH-1:0] w_cnt_next;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr    = s_tvalid && !w_full;

  assign w_byte       = r_head[7:0];
  assign w_completing = (r_lane == 2'd3) || r_head[8];
  assign w_out_free   = !r_m_tvalid || m_tready;
  assign w_pop        = r_head_valid && (!w_completing || w_out_free);
  assign w_head_load  = !w_empty && (!r_head_valid || w_pop);
  assign w_m_hs       = r_m_tvalid && m_tready;
  assign w_cnt_next   = (r_byte_cnt == {LEN_WIDTH{1'b1}}) ? r_byte_cnt
                        : r_byte_cnt + {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  // NOTE: the storage array has no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= {s_tlast, s_tdata};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_head_valid <= 1'b0;
      r_head       <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_head_load) begin
        r_head       <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr     <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        r_head_valid <= 1'b1;
      end else if (w_pop) begin
        r_head_valid <= 1'b0;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_word = {8'h00, r_lanes};
    w_keep = 4'b1111;
    case (r_lane)
      2'd0:    begin w_word[7:0]   = w_byte; w_keep = 4'b0001; end
      2'd1:    begin w_word[15:8]  = w_byte; w_keep = 4'b0011; end
      2'd2:    begin w_word[23:16] = w_byte; w_keep = 4'b0111; end
      default: begin w_word[31:24] = w_byte; w_keep = 4'b1111; end
    endcase
  end

  // Lanes are cleared on every completing pop, so lanes above the counter stay zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lane     <= 2'd0;
      r_lanes    <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
    end else begin
      if (w_pop && w_completing) begin
        r_lane     <= 2'd0;
        r_lanes    <= '0;
        r_m_tvalid <= 1'b1;
        r_m_tlast  <= r_head[8];
        r_m_tdata  <= w_word;
        r_m_tkeep  <= w_keep;
      end else begin
        if (w_pop) begin
          r_lane <= r_lane + 2'd1;
          case (r_lane)
            2'd0:    r_lanes[7:0]   <= w_byte;
            2'd1:    r_lanes[15:8]  <= w_byte;
            2'd2:    r_lanes[23:16] <= w_byte;
            default: r_lanes        <= r_lanes;
          endcase
        end
        if (m_tready) r_m_tvalid <= 1'b0;
      end
    end
  end

  // Pending length is single-entry: the next last-byte pop needs the output register free.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_byte_cnt   <= '0;
      r_pending    <= '0;
      r_frame_len  <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_pop) begin
        if (r_head[8]) begin
          r_pending  <= w_cnt_next;
          r_byte_cnt <= '0;
        end else begin
          r_byte_cnt <= w_cnt_next;
        end
      end
      r_frame_done <= w_m_hs && r_m_tlast;
      if (w_m_hs && r_m_tlast) r_frame_len <= r_pending;
      if (s_tvalid && w_full) r_overflow <= 1'b1;
      else if (clr_overflow)  r_overflow <= 1'b0;
    end
  end

  assign s_tready   = !w_full;
  assign m_tvalid   = r_m_tvalid;
  assign m_tlast    = r_m_tlast;
  assign m_tdata    = r_m_tdata;
  assign m_tkeep    = r_m_tkeep;
  assign frame_len  = r_frame_len;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_rx_frame_packer.sv
// Bench for rx_frame_packer: directed and random byte frames scored against a
// frame-level packing model, plus overflow, mid-frame reset and length saturation.
`timescale 1ns/1ps
module tb_rx_frame_packer;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic [15:0] frame_len;
  logic        frame_done;
  logic        overflow;
  logic        clr_overflow = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int ready_mode = 1;          // 0: stalled, 1: always ready, 2: random

  word_t      exp_words[$];
  int         exp_len[$];
  logic [7:0] cur[$];
  int         frame_cnt = 0;
  int         held_len  = 0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_keep;
  logic        prev_last;

  rx_frame_packer #(.FIFO_DEPTH(16), .LEN_WIDTH(16)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tlast      (s_tlast),
    .s_tdata      (s_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .m_tdata      (m_tdata),
    .m_tkeep      (m_tkeep),
    .frame_len    (frame_len),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: every 4 bytes or a last byte closes a word; a last byte closes the frame.
  task automatic model_push(input logic [7:0] b, input logic last);
    word_t w;
    cur.push_back(b);
    frame_cnt++;
    if (cur.size() == 4 || last) begin
      w.data = '0;
      for (int i = 0; i < cur.size(); i++) w.data = w.data | (32'(cur[i]) << (8 * i));
      w.keep = 4'((1 << cur.size()) - 1);
      w.last = last;
      exp_words.push_back(w);
      cur.delete();
    end
    if (last) begin
      exp_len.push_back(frame_cnt > 65535 ? 65535 : frame_cnt);
      frame_cnt = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    @(negedge clk);
    s_tvalid = 1'b1;
    s_tdata  = b;
    s_tlast  = last;
    while (!s_tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", s_tready, 1);
    model_push(b, last);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_words.size() != 0 || exp_len.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check({tag, "_words_left"}, exp_words.size(), 0);
    check({tag, "_lens_left"}, exp_len.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rstn = 1'b0;
    s_tvalid = 1'b0;
    clr_overflow = 1'b0;
    exp_words.delete();
    exp_len.delete();
    cur.delete();
    frame_cnt = 0;
    held_len = 0;
    repeat (2) @(negedge clk);
    check("rst_s_tready", s_tready, 1);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tkeep", m_tkeep, 0);
    check("rst_frame_len", frame_len, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    #1;
    rstn = 1'b1;
  endtask

  // Output side: drive m_tready, predict the handshake of the coming edge, check holds.
  always @(negedge clk) begin
    word_t w;
    case (ready_mode)
      0:       m_tready = 1'b0;
      1:       m_tready = 1'b1;
      default: m_tready = ($urandom_range(0, 9) < 7);
    endcase
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_data", m_tdata, prev_data);
        check("hold_keep", m_tkeep, prev_keep);
        check("hold_last", m_tlast, prev_last);
      end
      if (m_tvalid && m_tready) begin
        check("word_expected", exp_words.size() > 0, 1);
        if (exp_words.size() > 0) begin
          w = exp_words.pop_front();
          check("m_tdata", m_tdata, w.data);
          check("m_tkeep", m_tkeep, w.keep);
          check("m_tlast", m_tlast, w.last);
        end
      end
      if (frame_done) begin
        check("len_expected", exp_len.size() > 0, 1);
        if (exp_len.size() > 0) held_len = exp_len.pop_front();
        check("frame_len", frame_len, held_len);
      end else begin
        check("frame_len_hold", frame_len, held_len);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_keep  = m_tkeep;
      prev_last  = m_tlast;
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  len;
    bit  saw_full;

    do_reset();

    // Four-byte frame with latency check on the last byte.
    ready_mode = 1;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    @(negedge clk); check("lat_edge_n", m_tvalid, 0);
    @(negedge clk); check("lat_edge_n1", m_tvalid, 0);
    @(negedge clk); check("lat_edge_n2", m_tvalid, 1);
    check("lat_word", m_tdata, 32'h44332211);
    drain("t1");
    check("t1_frame_len", frame_len, 4);

    // Five-byte frame spills a one-byte tail word.
    for (int i = 1; i <= 5; i++) send_byte(8'(i), i == 5);
    drain("t2");
    check("t2_frame_len", frame_len, 5);

    // One-byte frame followed by a three-byte frame.
    send_byte(8'hAA, 1'b1);
    send_byte(8'hB1, 1'b0);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hB3, 1'b1);
    drain("t3");
    check("t3_frame_len", frame_len, 3);

    // Random frames, random gaps, random backpressure.
    ready_mode = 2;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        send_byte(8'($urandom), i == len - 1);
      end
    end
    ready_mode = 1;
    drain("rand");

    // Overflow: output stalled while the stream keeps coming.
    ready_mode = 0;
    @(negedge clk);
    check("ovf_pre", overflow, 0);
    saw_full = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = 8'(i + 1);
      s_tlast  = 1'b0;
      if (!s_tready) saw_full = 1'b1;
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    check("ovf_saw_full", saw_full, 1);
    check("ovf_set", overflow, 1);
    check("ovf_held_valid", m_tvalid, 1);
    check("ovf_held_data", m_tdata, 32'h04030201);
    check("ovf_held_keep", m_tkeep, 4'b1111);
    check("ovf_held_last", m_tlast, 0);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check("ovf_cleared", overflow, 0);
    clr_overflow = 1'b1;
    s_tvalid = 1'b1;
    check("ovf_still_full", s_tready, 0);
    @(negedge clk);
    clr_overflow = 1'b0;
    s_tvalid = 1'b0;
    check("ovf_set_wins", overflow, 1);
    do_reset();
    ready_mode = 1;

    // Reset mid-frame, then a clean frame with no stale lanes.
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b0);
    do_reset();
    for (int i = 1; i <= 4; i++) send_byte(8'(i), i == 4);
    drain("rst");
    check("rst_frame_len_after", frame_len, 4);

    // Long frame saturates the length counter.
    for (int i = 0; i < 70000; i++) send_byte(8'(i), i == 69999);
    drain("sat");
    check("sat_frame_len", frame_len, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
